// File: rtl/lb_rr_arbiter_pkg.sv
// Shared types and constants for the local-bus round-robin arbiter.
package lb_rr_arbiter_pkg;

   // Default number of bus masters and grant-to-decode timeout in cycles.
   localparam int LB_ARB_NUM_MASTERS     = 4;
   localparam int LB_ARB_DEFAULT_TIMEOUT = 10;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      STROBE  = 2'd2,
      RELEASE = 2'd3
   } lb_arb_state_e;

   // Width of a master index; one bit is kept even for a single master.
   function automatic int lb_arb_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Wrap an index in [0, 2n) back into [0, n).
   function automatic int lb_arb_wrap_idx(input int idx, input int n);
      return (idx >= n) ? (idx - n) : idx;
   endfunction

endpackage

// File: rtl/lb_rr_arbiter_picker.sv
// Combinational round-robin priority picker: first active request at or
// above the pointer, searching upward with wrap-around.
module rr_priority_picker
   import lb_rr_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = LB_ARB_NUM_MASTERS,
   parameter int IDX_W       = lb_arb_idx_w(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IDX_W-1:0]       ptr_i,
   output logic [NUM_MASTERS-1:0] winner_o,
   output logic [IDX_W-1:0]       winner_idx_o
);

   logic found;
   int   cand;

   // Scan from the pointer upward and keep the first requester found.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path can infer a latch.
      winner_o     = '0;
      winner_idx_o = '0;
      found        = 1'b0;
      cand         = 0;
      for (int off = 0; off < NUM_MASTERS; off++) begin
         cand = lb_arb_wrap_idx(int'(ptr_i) + off, NUM_MASTERS);
         if (!found && req_i[cand]) begin
            found          = 1'b1;
            winner_o[cand] = 1'b1;
            winner_idx_o   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/lb_rr_arbiter.sv
// Round-robin arbiter for the shared 16-bit local bus.
// Grants one master at a time, frames the transfer with target_ready_o and a
// single-cycle data_strobe_o, and aborts with error_o when no slave decodes
// the address within CLK_MAX_TIMEOUT cycles of the grant.
// Optional statistics counters are built when LB_ARB_STATS_EN is defined.
module lb_rr_arbiter
   import lb_rr_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS     = LB_ARB_NUM_MASTERS,
   parameter int CLK_MAX_TIMEOUT = LB_ARB_DEFAULT_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] barq_i,
   output logic [NUM_MASTERS-1:0] bagd_o,
   output logic                   target_ready_o,
   input  logic                   address_valid_i,
   output logic                   data_strobe_o,
   output logic                   error_o,
   output logic                   busy_o
`ifdef LB_ARB_STATS_EN
   ,
   output logic [15:0]            grant_cnt_o,
   output logic [7:0]             timeout_cnt_o
`endif
);

   localparam int IDX_W = lb_arb_idx_w(NUM_MASTERS);
   localparam int TMR_W = $clog2(CLK_MAX_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_MAX_TIMEOUT - 1);

   lb_arb_state_e          state_q, state_d;
   logic [NUM_MASTERS-1:0] bagd_q, bagd_d;
   logic                   target_ready_q, target_ready_d;
   logic                   data_strobe_q, data_strobe_d;
   logic                   error_q, error_d;
   logic                   busy_q, busy_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [TMR_W-1:0]       timer_q, timer_d;

   logic [NUM_MASTERS-1:0] pick_onehot;
   logic [IDX_W-1:0]       pick_idx;
   logic                   owner_req;
   logic [IDX_W-1:0]       owner_next;

   rr_priority_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (IDX_W)
   ) u_picker (
      .req_i        (barq_i),
      .ptr_i        (ptr_q),
      .winner_o     (pick_onehot),
      .winner_idx_o (pick_idx)
   );

   // The owner still wants the bus, and the master after it is next in line.
   assign owner_req  = barq_i[owner_q];
   assign owner_next = IDX_W'(lb_arb_wrap_idx(int'(owner_q) + 1, NUM_MASTERS));

   // Next-state and next-output logic for the grant/strobe/release sequence.
   always_comb begin
      state_d        = state_q;
      bagd_d         = bagd_q;
      target_ready_d = target_ready_q;
      data_strobe_d  = 1'b0;
      error_d        = 1'b0;
      ptr_d          = ptr_q;
      owner_d        = owner_q;
      timer_d        = timer_q;
      case (state_q)
         IDLE: begin
            if (|barq_i) begin
               bagd_d         = pick_onehot;
               owner_d        = pick_idx;
               target_ready_d = 1'b1;
               timer_d        = '0;
               state_d        = GRANT;
            end
         end
         GRANT: begin
            timer_d = timer_q + 1'b1;
            // A decode in the timeout cycle still completes the transfer.
            if (address_valid_i) begin
               data_strobe_d = 1'b1;
               state_d       = STROBE;
            end else if (timer_q == TMR_LAST) begin
               error_d        = 1'b1;
               target_ready_d = 1'b0;
               state_d        = RELEASE;
            end else if (!owner_req) begin
               // Owner gave up before any slave answered: quiet abort.
               bagd_d         = '0;
               target_ready_d = 1'b0;
               ptr_d          = owner_next;
               state_d        = IDLE;
            end
         end
         STROBE: begin
            target_ready_d = 1'b0;
            state_d        = RELEASE;
         end
         RELEASE: begin
            target_ready_d = 1'b0;
            if (!owner_req) begin
               bagd_d  = '0;
               ptr_d   = owner_next;
               state_d = IDLE;
            end
         end
         default: begin
            bagd_d         = '0;
            target_ready_d = 1'b0;
            state_d        = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset returns to an idle, ungranted bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         bagd_q         <= '0;
         target_ready_q <= 1'b0;
         data_strobe_q  <= 1'b0;
         error_q        <= 1'b0;
         busy_q         <= 1'b0;
         ptr_q          <= '0;
         owner_q        <= '0;
         timer_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q        <= state_d;
         bagd_q         <= bagd_d;
         target_ready_q <= target_ready_d;
         data_strobe_q  <= data_strobe_d;
         error_q        <= error_d;
         busy_q         <= busy_d;
         ptr_q          <= ptr_d;
         owner_q        <= owner_d;
         timer_q        <= timer_d;
      end
   end

   assign bagd_o         = bagd_q;
   assign target_ready_o = target_ready_q;
   assign data_strobe_o  = data_strobe_q;
   assign error_o        = error_q;
   assign busy_o         = busy_q;

`ifdef LB_ARB_STATS_EN
   logic [15:0] grant_cnt_q, grant_cnt_d;
   logic [7:0]  timeout_cnt_q, timeout_cnt_d;

   // Saturating counts of completed strobes and timeout pulses.
   always_comb begin
      grant_cnt_d   = grant_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      if (state_q == STROBE && grant_cnt_q != '1) begin
         grant_cnt_d = grant_cnt_q + 1'b1;
      end
      if (error_d && timeout_cnt_q != '1) begin
         timeout_cnt_d = timeout_cnt_q + 1'b1;
      end
   end

   // Statistics registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q   <= '0;
         timeout_cnt_q <= '0;
      end else begin
         grant_cnt_q   <= grant_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

   assign grant_cnt_o   = grant_cnt_q;
   assign timeout_cnt_o = timeout_cnt_q;
`endif

endmodule
